// File: rtl/pipe_sel_mux.sv
// Registered NUM_IN-way selector with a valid/ready handshake and a 2-entry skid buffer.
// Define PIPE_SEL_MUX_RANGE_CHECK_EN to build the sticky out-of-range select flag err_sel.
module pipe_sel_mux #(
    parameter int WIDTH  = 5,
    parameter int NUM_IN = 3,
    parameter int SEL_W  = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IN*WIDTH-1:0] in_bus,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out,
    output logic                    out_valid,
    input  logic                    out_ready,
    input  logic                    flush,
    output logic                    err_sel
);

    logic [WIDTH-1:0] skid_data;
    logic             skid_valid;
    logic             ready_q;
    logic [WIDTH-1:0] sel_value;
    logic             accept;
    logic             depart;

    assign accept   = in_valid && ready_q && !flush;
    assign depart   = out_valid && out_ready;
    assign in_ready = ready_q;

    // Out-of-range selects fall through to source 0.
    always_comb begin
        sel_value = in_bus[WIDTH-1:0];
        for (int k = 1; k < NUM_IN; k++) begin
            if (sel == SEL_W'(k)) begin
                sel_value = in_bus[k*WIDTH +: WIDTH];
            end
        end
    end

    // ready_q mirrors the next skid_valid so in_ready never sees out_ready combinationally.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out        <= '0;
            out_valid  <= 1'b0;
            skid_data  <= '0;
            skid_valid <= 1'b0;
            ready_q    <= 1'b1;
        end else if (flush) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            ready_q    <= 1'b1;
        end else if (!out_valid) begin
            if (accept) begin
                out       <= sel_value;
                out_valid <= 1'b1;
            end
        end else if (!skid_valid) begin
            if (accept && depart) begin
                out <= sel_value;
            end else if (accept) begin
                skid_data  <= sel_value;
                skid_valid <= 1'b1;
                ready_q    <= 1'b0;
            end else if (depart) begin
                out_valid <= 1'b0;
            end
        end else if (depart) begin
            out        <= skid_data;
            skid_valid <= 1'b0;
            ready_q    <= 1'b1;
        end
    end

`ifdef PIPE_SEL_MUX_RANGE_CHECK_EN
    localparam logic [SEL_W:0] NUM_IN_LIM = (SEL_W+1)'(NUM_IN);

    logic err_q;

    // Sticky until reset; flush deliberately leaves it set.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (accept && ({1'b0, sel} >= NUM_IN_LIM)) begin
            err_q <= 1'b1;
        end
    end

    assign err_sel = err_q;
`else
    assign err_sel = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_sel_mux.sv
// Bench for pipe_sel_mux: directed checks on the default build plus a long random run on a
// 32-bit, 8-source build, both compared every cycle against a queue-based reference.
module tb_pipe_sel_mux;

`ifdef PIPE_SEL_MUX_RANGE_CHECK_EN
    localparam bit RANGE_EN = 1'b1;
`else
    localparam bit RANGE_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    // Default build (WIDTH=5, NUM_IN=3, SEL_W=2)
    logic [14:0] d_bus = '0;
    logic [1:0]  d_sel = '0;
    logic        d_in_valid = 1'b0;
    logic        d_in_ready;
    logic [4:0]  d_out;
    logic        d_out_valid;
    logic        d_out_ready = 1'b0;
    logic        d_flush = 1'b0;
    logic        d_err_sel;

    // Wide build (WIDTH=32, NUM_IN=8, SEL_W=3)
    logic [255:0] w_bus = '0;
    logic [2:0]   w_sel = '0;
    logic         w_in_valid = 1'b0;
    logic         w_in_ready;
    logic [31:0]  w_out;
    logic         w_out_valid;
    logic         w_out_ready = 1'b0;
    logic         w_flush = 1'b0;
    logic         w_err_sel;

    int checks = 0;
    int errors = 0;

    pipe_sel_mux #(.WIDTH(5), .NUM_IN(3), .SEL_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_bus(d_bus), .sel(d_sel),
        .in_valid(d_in_valid), .in_ready(d_in_ready), .out(d_out),
        .out_valid(d_out_valid), .out_ready(d_out_ready), .flush(d_flush),
        .err_sel(d_err_sel)
    );

    pipe_sel_mux #(.WIDTH(32), .NUM_IN(8), .SEL_W(3)) dutw (
        .clk(clk), .rst_n(rst_n), .in_bus(w_bus), .sel(w_sel),
        .in_valid(w_in_valid), .in_ready(w_in_ready), .out(w_out),
        .out_valid(w_out_valid), .out_ready(w_out_ready), .flush(w_flush),
        .err_sel(w_err_sel)
    );

    always #5 clk = ~clk;

    // Reference: a FIFO of at most two accepted items; out shows the head, or the last head once empty.
    logic [4:0]  dq[$];
    logic [31:0] wq[$];
    logic [4:0]  dLast = '0;
    logic [31:0] wLast = '0;
    bit          dErr = 1'b0;
    bit          wErr = 1'b0;
    bit          live = 1'b0;
    bit          dAcc, dDep, wAcc, wDep;
    bit          wHold = 1'b0;
    logic [31:0] wHoldOut = '0;

    initial begin
        forever begin
            @(posedge clk);
            wHold    = live && rst_n && w_out_valid && !w_out_ready && !w_flush;
            wHoldOut = w_out;
            if (!rst_n) begin
                dq.delete();
                wq.delete();
                dLast = '0;
                wLast = '0;
                dErr  = 1'b0;
                wErr  = 1'b0;
                live  = 1'b1;
            end else begin
                dAcc = d_in_valid && (dq.size() < 2) && !d_flush;
                dDep = (dq.size() > 0) && d_out_ready;
                if (d_flush) begin
                    dq.delete();
                end else begin
                    if (dDep) void'(dq.pop_front());
                    if (dAcc) dq.push_back((d_sel < 2'd3) ? d_bus[d_sel*5 +: 5] : d_bus[4:0]);
                end
                if (RANGE_EN && dAcc && d_sel >= 2'd3) dErr = 1'b1;
                if (dq.size() > 0) dLast = dq[0];

                wAcc = w_in_valid && (wq.size() < 2) && !w_flush;
                wDep = (wq.size() > 0) && w_out_ready;
                if (w_flush) begin
                    wq.delete();
                end else begin
                    if (wDep) void'(wq.pop_front());
                    if (wAcc) wq.push_back(w_bus[w_sel*32 +: 32]);
                end
                if (wq.size() > 0) wLast = wq[0];
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Per-cycle comparison of both instances against the reference
    initial begin
        forever begin
            @(negedge clk);
            if (live) begin
                checkOutput("d_out_valid", 32'(d_out_valid), 32'(dq.size() > 0));
                checkOutput("d_in_ready", 32'(d_in_ready), 32'(dq.size() < 2));
                checkOutput("d_out", 32'(d_out), 32'(dLast));
                checkOutput("d_err_sel", 32'(d_err_sel), 32'(dErr));
                checkOutput("w_out_valid", 32'(w_out_valid), 32'(wq.size() > 0));
                checkOutput("w_in_ready", 32'(w_in_ready), 32'(wq.size() < 2));
                checkOutput("w_out", w_out, wLast);
                checkOutput("w_err_sel", 32'(w_err_sel), 32'(wErr));
                if (wHold) checkOutput("w_out_stable", w_out, wHoldOut);
            end
        end
    end

    task automatic applyStimulus(input bit v, input logic [1:0] s, input logic [14:0] bus,
                                 input bit rdy, input bit fl);
        d_in_valid  = v;
        d_sel       = s;
        d_bus       = bus;
        d_out_ready = rdy;
        d_flush     = fl;
        @(negedge clk);
    endtask

    logic [14:0] srcs;

    initial begin
        srcs = {5'h1F, 5'h11, 5'h03};

        // Reset
        rst_n = 1'b0;
        applyStimulus(1'b1, 2'd1, srcs, 1'b1, 1'b0);
        applyStimulus(1'b1, 2'd1, srcs, 1'b1, 1'b0);
        checkOutput("reset_out", 32'(d_out), 32'h0);
        checkOutput("reset_out_valid", 32'(d_out_valid), 32'h0);
        checkOutput("reset_in_ready", 32'(d_in_ready), 32'h1);
        checkOutput("reset_err", 32'(d_err_sel), 32'h0);
        rst_n = 1'b1;

        // Streaming selects
        applyStimulus(1'b1, 2'd0, srcs, 1'b1, 1'b0);
        checkOutput("stream_sel0", 32'(d_out), 32'h03);
        checkOutput("stream_valid0", 32'(d_out_valid), 32'h1);
        applyStimulus(1'b1, 2'd1, srcs, 1'b1, 1'b0);
        checkOutput("stream_sel1", 32'(d_out), 32'h11);
        applyStimulus(1'b1, 2'd2, srcs, 1'b1, 1'b0);
        checkOutput("stream_sel2", 32'(d_out), 32'h1F);
        applyStimulus(1'b0, 2'd0, srcs, 1'b1, 1'b0);
        checkOutput("stream_drain", 32'(d_out_valid), 32'h0);

        // Back-pressure: A, B, C
        applyStimulus(1'b1, 2'd0, 15'h000A, 1'b0, 1'b0);
        checkOutput("bp_a_out", 32'(d_out), 32'h0A);
        checkOutput("bp_a_ready", 32'(d_in_ready), 32'h1);
        applyStimulus(1'b1, 2'd0, 15'h000B, 1'b0, 1'b0);
        checkOutput("bp_b_hold", 32'(d_out), 32'h0A);
        checkOutput("bp_b_ready", 32'(d_in_ready), 32'h0);
        applyStimulus(1'b1, 2'd0, 15'h000C, 1'b0, 1'b0);
        checkOutput("bp_c_refused", 32'(d_out), 32'h0A);
        applyStimulus(1'b1, 2'd0, 15'h000C, 1'b1, 1'b0);
        checkOutput("bp_b_out", 32'(d_out), 32'h0B);
        checkOutput("bp_ready_back", 32'(d_in_ready), 32'h1);
        applyStimulus(1'b1, 2'd0, 15'h000C, 1'b1, 1'b0);
        checkOutput("bp_c_out", 32'(d_out), 32'h0C);
        applyStimulus(1'b0, 2'd0, 15'h0000, 1'b1, 1'b0);
        checkOutput("bp_drain", 32'(d_out_valid), 32'h0);

        // Flush while full
        applyStimulus(1'b1, 2'd0, 15'h0001, 1'b0, 1'b0);
        applyStimulus(1'b1, 2'd0, 15'h0002, 1'b0, 1'b0);
        checkOutput("fl_full", 32'(d_in_ready), 32'h0);
        applyStimulus(1'b1, 2'd0, 15'h0003, 1'b0, 1'b1);
        checkOutput("fl_valid", 32'(d_out_valid), 32'h0);
        checkOutput("fl_ready", 32'(d_in_ready), 32'h1);
        applyStimulus(1'b0, 2'd0, 15'h0000, 1'b1, 1'b0);
        checkOutput("fl_no_item", 32'(d_out_valid), 32'h0);
        checkOutput("fl_data_hold", 32'(d_out), 32'h01);

        // Out-of-range select
        applyStimulus(1'b1, 2'd3, {5'h1F, 5'h11, 5'h07}, 1'b1, 1'b0);
        checkOutput("oor_out", 32'(d_out), 32'h07);
        checkOutput("oor_err", 32'(d_err_sel), 32'(RANGE_EN));
        applyStimulus(1'b0, 2'd0, 15'h0000, 1'b1, 1'b1);
        checkOutput("oor_err_after_flush", 32'(d_err_sel), 32'(RANGE_EN));

        // Reset while full
        applyStimulus(1'b1, 2'd0, 15'h0004, 1'b0, 1'b0);
        applyStimulus(1'b1, 2'd0, 15'h0005, 1'b0, 1'b0);
        checkOutput("rf_full", 32'(d_in_ready), 32'h0);
        rst_n = 1'b0;
        applyStimulus(1'b1, 2'd1, srcs, 1'b1, 1'b0);
        checkOutput("rf_out", 32'(d_out), 32'h0);
        checkOutput("rf_valid", 32'(d_out_valid), 32'h0);
        checkOutput("rf_ready", 32'(d_in_ready), 32'h1);
        checkOutput("rf_err", 32'(d_err_sel), 32'h0);
        rst_n = 1'b1;
        applyStimulus(1'b1, 2'd2, srcs, 1'b1, 1'b0);
        checkOutput("rf_next_item", 32'(d_out), 32'h1F);
        applyStimulus(1'b0, 2'd0, 15'h0000, 1'b1, 1'b0);

        // Random traffic on the wide build
        for (int i = 0; i < 10000; i++) begin
            w_in_valid  = ($urandom_range(0, 3) != 0);
            w_out_ready = ($urandom_range(0, 2) != 0);
            w_flush     = ($urandom_range(0, 63) == 0);
            w_sel       = 3'($urandom_range(0, 7));
            for (int k = 0; k < 8; k++) w_bus[k*32 +: 32] = $urandom;
            @(negedge clk);
        end
        w_in_valid  = 1'b0;
        w_out_ready = 1'b1;
        w_flush     = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rand_drained", 32'(w_out_valid), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_sel_mux.md
# pipe_sel_mux

Parametrised, registered N-input selector with a valid/ready handshake and a 2-entry skid buffer. It generalises the CPU's fixed 5-bit 2:1 destination/operand select to WIDTH bits and NUM_IN sources, and captures the selected value into a pipeline-boundary register. It sits between decode and execute, where destination-register and operand choices are registered. It absorbs one cycle of downstream back-pressure without a combinational ready path and supports pipeline flush.

## Interface
- Clocking: one clock; reset is synchronous and active-low.
- Parameters:
  - WIDTH, 5: bits per source.
  - NUM_IN, 3: number of sources, 2..8.
  - SEL_W, 2: select width. Must satisfy 2^SEL_W >= NUM_IN.
- Ports:
  - clk  in  1: rising-edge clock.
  - rst_n  in  1: synchronous active-low reset.
  - in_bus  in  NUM_IN*WIDTH: source k occupies bits [k*WIDTH +: WIDTH]; source 0 is at the LSBs.
  - sel  in  SEL_W: source index, sampled with in_bus on acceptance.
  - in_valid  in  1: upstream holds a valid sel/in_bus.
  - in_ready  out  1: block can accept; equals NOT skid_valid and is driven from a register only.
  - out  out  WIDTH: registered selected value.
  - out_valid  out  1: out holds a valid item.
  - out_ready  in  1: downstream consumes out this cycle.
  - flush  in  1: discard all held items.
  - err_sel  out  1: sticky out-of-range select flag (see Configuration).

## Operation
- Acceptance: in_valid && in_ready && !flush. Value = source[sel] if sel < NUM_IN, otherwise source 0.
- Departure: out_valid && out_ready.
- State is held in main register (out, out_valid) and skid register (skid_data, skid_valid). Modes:
  - EMPTY: out_valid=0.
    - accept → ONE; out ← value.
  - ONE: out_valid=1, skid_valid=0.
    - accept && depart → ONE; out ← value.
    - accept && !depart → FULL; skid ← value, out holds.
    - !accept && depart → EMPTY.
    - Otherwise hold.
  - FULL: out_valid=1, skid_valid=1, in_ready=0.
    - depart → ONE; out ← skid_data, skid_valid ← 0.
    - Otherwise hold.
- flush (priority below reset): out_valid ← 0, skid_valid ← 0, next mode EMPTY. An acceptance in the same cycle is discarded. Data registers hold their last value.
- Ordering: items leave in acceptance order. No item is duplicated or lost except by flush or reset.
- While out_valid=1 and out_ready=0, out must not change.

## Timing
- Latency: 1 cycle. An item accepted at edge n is visible on out, with out_valid=1, after edge n.
- Throughput: 1 item/cycle while out_ready=1.
- in_ready depends only on registered state; there is no combinational path from out_ready.
- Reset (rst_n=0 at an edge) sets: out=0, out_valid=0, skid_data=0, skid_valid=0, err_sel=0.
  - in_ready therefore reads 1 after the first reset edge.
  - All inputs are ignored while rst_n=0.
  - Reset mid-transfer drops both held items.
- Simultaneous accept+depart in ONE: the new item replaces out at the same edge; no bubble.
- Depart in FULL re-opens in_ready at the next cycle, not the same one.

## Configuration
- PIPE_SEL_MUX_RANGE_CHECK_EN defined:
  - err_sel is set at the edge of any acceptance with sel >= NUM_IN.
  - It stays 1 until reset; flush does not clear it.
- Not defined: err_sel is tied to 0 and no checking logic is built.
- In both cases, out-of-range selects return source 0.

## Test plan
- Defaults (WIDTH=5, NUM_IN=3), out_ready=1: push sel=0,1,2 with sources 0x03/0x11/0x1F → out shows 0x03, 0x11, 0x1F on consecutive cycles, each one cycle after its acceptance.
- out_ready=0, push 3 items A,B,C → A on out, B in skid, in_ready=0 in the cycle after B is accepted, C not accepted. Raise out_ready → A, B, C emerge in order; in_ready returns one cycle after A departs.
- FULL mode, assert flush for one cycle with in_valid=1 → out_valid=0 and in_ready=1 next cycle; the flushed-cycle item never appears on out.
- Drive sel=3 with NUM_IN=3:
  - macro defined → out = source 0, err_sel=1 and still 1 after a subsequent flush.
  - macro undefined → err_sel stays 0.
- FULL mode, drop rst_n for one edge → out=0, out_valid=0, in_ready=1; the next accepted item emerges normally.
- Random in_valid/out_ready for 10k cycles with WIDTH=32, NUM_IN=8 against a scoreboard → exact order and values; out stable whenever out_valid && !out_ready.
